// File: rtl/spmm_pkg.sv
// +----------------------------------------------------------------------+
// | spmm_pkg : shared SpMM geometry, element type and encoder helpers     |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package spmm_pkg;

  localparam int N     = 16;
  localparam int W     = 8;
  localparam int lgN   = $clog2(N);
  localparam int dbLgN = 2 * lgN;

  typedef logic [W-1:0] data_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_PACK = 3'd2,
    S_WAIT = 3'd3,
    S_SEND = 3'd4
  } enc_state_t;

  // An empty matrix still produces one (all-zero) beat.
  function automatic logic [lgN:0] beats_for(input logic [dbLgN:0] count);
    logic [dbLgN:0] b;
    b = (count + (dbLgN+1)'(N - 1)) >> lgN;
    return (b == '0) ? (lgN+1)'(1) : (lgN+1)'(b);
  endfunction

endpackage

`default_nettype wire

// File: rtl/row_compact.sv
// +----------------------------------------------------------------------+
// | row_compact : packs one row's nonzeros into low lanes, plus popcount  |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module row_compact
  import spmm_pkg::*;
(
  input  data_t [N-1:0]          row,
  output logic  [N-1:0][lgN-1:0] col,
  output data_t [N-1:0]          data,
  output logic  [lgN:0]          count
);

  always_comb begin
    col   = '0;
    data  = '0;
    count = '0;
    for (int j = 0; j < N; j++) begin
      if (row[j] != '0) begin
        col[count[lgN-1:0]]  = lgN'(j);
        data[count[lgN-1:0]] = row[j];
        count                = count + (lgN+1)'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/csr_encoder.sv
// +----------------------------------------------------------------------+
// | csr_encoder : dense N x N matrix in, CSR nonzero beat burst out       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module csr_encoder
  import spmm_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  output logic                      in_ready,
  input  logic                      in_start,
  input  data_t [3:0][N-1:0]        in_data,
  input  logic                      lhs_ready,
  output logic                      lhs_start,
  output logic  [N-1:0][dbLgN-1:0]  lhs_ptr,
  output logic  [N-1:0][lgN-1:0]    lhs_col,
  output data_t [N-1:0]             lhs_data,
  output logic                      busy,
  output logic  [dbLgN:0]           nnz
);

  localparam int LB = N / 4;

  enc_state_t       state;
  logic [lgN-1:0]   load_beat;
  logic [lgN-1:0]   row;
  logic [dbLgN:0]   cum;
  logic             pend;
  logic [lgN:0]     send_beat;
  logic [lgN:0]     num_beats;

  data_t [N-1:0]    mat [N];
  logic [lgN-1:0]   sbuf_col  [N*N];
  data_t            sbuf_data [N*N];

  logic [N-1:0][lgN-1:0] rc_col;
  data_t [N-1:0]         rc_data;
  logic [lgN:0]          rc_count;
  logic [dbLgN:0]        cum_new;

  logic [lgN-1:0]        beat_sel;
  logic [N-1:0][lgN-1:0] beat_col;
  data_t [N-1:0]         beat_data;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state != S_IDLE);

  row_compact u_row_compact (
    .row   (mat[row]),
    .col   (rc_col),
    .data  (rc_data),
    .count (rc_count)
  );

  assign cum_new = cum + (dbLgN+1)'(rc_count);

  // Stale entries from an earlier, larger matrix are masked against nnz.
  always_comb begin
    beat_sel  = (state == S_SEND) ? send_beat[lgN-1:0] : '0;
    beat_col  = '0;
    beat_data = '0;
    for (int j = 0; j < N; j++) begin
      if ({1'b0, beat_sel, lgN'(j)} < nnz) begin
        beat_col[j]  = sbuf_col[{beat_sel, lgN'(j)}];
        beat_data[j] = sbuf_data[{beat_sel, lgN'(j)}];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (state == S_IDLE && in_start) begin
      for (int i = 0; i < 4; i++) mat[i] <= in_data[i];
    end
    if (state == S_LOAD) begin
      for (int i = 0; i < 4; i++) mat[lgN'(4 * int'(load_beat) + i)] <= in_data[i];
    end
    if (state == S_PACK) begin
      for (int j = 0; j < N; j++) begin
        if ((lgN+1)'(j) < rc_count) begin
          sbuf_col[cum[dbLgN-1:0] + dbLgN'(j)]  <= rc_col[j];
          sbuf_data[cum[dbLgN-1:0] + dbLgN'(j)] <= rc_data[j];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      load_beat <= '0;
      row       <= '0;
      cum       <= '0;
      pend      <= 1'b0;
      send_beat <= '0;
      num_beats <= (lgN+1)'(1);
      nnz       <= '0;
      lhs_start <= 1'b0;
      lhs_ptr   <= '0;
      lhs_col   <= '0;
      lhs_data  <= '0;
    end else begin
      lhs_start <= 1'b0;
      if (lhs_ready && state != S_IDLE && state != S_SEND) pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (in_start) begin
            state     <= (LB == 1) ? S_PACK : S_LOAD;
            load_beat <= lgN'(1);
            row       <= '0;
            cum       <= '0;
          end
        end
        S_LOAD: begin
          if (load_beat == lgN'(LB - 1)) state <= S_PACK;
          load_beat <= load_beat + lgN'(1);
        end
        S_PACK: begin
          lhs_ptr[row] <= cum_new[dbLgN-1:0] - dbLgN'(1);
          cum          <= cum_new;
          row          <= row + lgN'(1);
          if (row == lgN'(N - 1)) begin
            state     <= S_WAIT;
            nnz       <= cum_new;
            num_beats <= beats_for(cum_new);
          end
        end
        S_WAIT: begin
          if (pend) begin
            state     <= S_SEND;
            pend      <= 1'b0;
            lhs_start <= 1'b1;
            lhs_col   <= beat_col;
            lhs_data  <= beat_data;
            send_beat <= (lgN+1)'(1);
          end
        end
        S_SEND: begin
          if (send_beat == num_beats) begin
            state    <= S_IDLE;
            lhs_col  <= '0;
            lhs_data <= '0;
          end else begin
            lhs_col   <= beat_col;
            lhs_data  <= beat_data;
            send_beat <= send_beat + (lgN+1)'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_csr_encoder.sv
// +----------------------------------------------------------------------+
// | tb_csr_encoder : directed + random matrices against a CSR model       |
// | rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_csr_encoder;

  logic                   clock = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_start = 1'b0;
  logic                   lhs_ready = 1'b0;
  logic [3:0][15:0][7:0]  in_data = '0;
  logic                   in_ready, lhs_start, busy;
  logic [15:0][7:0]       lhs_ptr;
  logic [15:0][3:0]       lhs_col;
  logic [15:0][7:0]       lhs_data;
  logic [8:0]             nnz;

  csr_encoder dut (
    .clock     (clock),
    .reset     (reset),
    .in_ready  (in_ready),
    .in_start  (in_start),
    .in_data   (in_data),
    .lhs_ready (lhs_ready),
    .lhs_start (lhs_start),
    .lhs_ptr   (lhs_ptr),
    .lhs_col   (lhs_col),
    .lhs_data  (lhs_data),
    .busy      (busy),
    .nnz       (nnz)
  );

  always #5 clock = ~clock;

  logic [7:0] mat [16][16];
  int         n_checks = 0;
  int         n_pass = 0;

  int         m_nnz, m_beats;
  logic [7:0] m_ptr  [16];
  logic [3:0] m_col  [256];
  logic [7:0] m_data [256];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Row-major list of nonzeros; ptr is running count minus one, mod 256.
  task automatic model();
    int n;
    n = 0;
    for (int i = 0; i < 256; i++) begin
      m_col[i]  = '0;
      m_data[i] = '0;
    end
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 16; c++) begin
        if (mat[r][c] != 8'd0) begin
          m_col[n]  = 4'(c);
          m_data[n] = mat[r][c];
          n++;
        end
      end
      m_ptr[r] = 8'((n + 255) % 256);
    end
    m_nnz   = n;
    m_beats = (n == 0) ? 1 : (n + 15) / 16;
  endtask

  function automatic logic [63:0] exp_col(input int b);
    logic [15:0][3:0] v;
    for (int j = 0; j < 16; j++) v[j] = m_col[b * 16 + j];
    return v;
  endfunction

  function automatic logic [127:0] exp_data(input int b);
    logic [15:0][7:0] v;
    for (int j = 0; j < 16; j++) v[j] = m_data[b * 16 + j];
    return v;
  endfunction

  function automatic logic [127:0] exp_ptr();
    logic [15:0][7:0] v;
    for (int r = 0; r < 16; r++) v[r] = m_ptr[r];
    return v;
  endfunction

  task automatic fill_random();
    int d;
    d = $urandom_range(0, 100);
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        mat[r][c] = ($urandom_range(0, 99) < d) ? 8'($urandom_range(1, 255)) : 8'd0;
  endtask

  // ra: cycle (relative to in_start) of the single lhs_ready pulse.
  task automatic run_matrix(input string tag, input int ra, input bit junk, input int abort_at);
    logic [3:0][15:0][7:0] beat;
    int exp_start, seen;
    model();
    exp_start = (ra + 2 > 21) ? ra + 2 : 21;
    seen = -1;
    check({tag, "_in_ready"}, 256'(in_ready), 256'(1));
    for (int k = 0; k < exp_start + 40 && seen < 0; k++) begin
      if (k > 0 && lhs_start) begin
        seen = k;
      end else begin
        if (junk && k == 24) begin
          check({tag, "_wait_busy"}, 256'(busy), 256'(1));
          check({tag, "_wait_in_ready"}, 256'(in_ready), 256'(0));
          check({tag, "_wait_col"}, 256'(lhs_col), 256'(0));
          check({tag, "_wait_data"}, 256'(lhs_data), 256'(0));
        end
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 16; j++)
            beat[i][j] = 8'hFF;
        if (k < 4) begin
          for (int i = 0; i < 4; i++)
            for (int j = 0; j < 16; j++)
              beat[i][j] = mat[4 * k + i][j];
        end
        in_data   = beat;
        in_start  = (k == 0) || (junk && k == 25);
        lhs_ready = (k == ra);
        step();
      end
    end
    in_start  = 1'b0;
    lhs_ready = 1'b0;
    check({tag, "_start_cycle"}, 256'(seen), 256'(exp_start));
    if (seen < 0) return;
    check({tag, "_nnz"}, 256'(nnz), 256'(m_nnz));
    for (int b = 0; b < m_beats; b++) begin
      check($sformatf("%s_b%0d_start", tag, b), 256'(lhs_start), 256'(b == 0));
      check($sformatf("%s_b%0d_col", tag, b), 256'(lhs_col), 256'(exp_col(b)));
      check($sformatf("%s_b%0d_data", tag, b), 256'(lhs_data), 256'(exp_data(b)));
      if (b == 0 || b == m_beats - 1)
        check($sformatf("%s_b%0d_ptr", tag, b), 256'(lhs_ptr), 256'(exp_ptr()));
      lhs_ready = 1'b1;
      if (b == abort_at) begin
        reset = 1'b1;
        step();
        reset     = 1'b0;
        lhs_ready = 1'b0;
        check({tag, "_rst_in_ready"}, 256'(in_ready), 256'(1));
        check({tag, "_rst_busy"}, 256'(busy), 256'(0));
        check({tag, "_rst_start"}, 256'(lhs_start), 256'(0));
        check({tag, "_rst_col"}, 256'(lhs_col), 256'(0));
        check({tag, "_rst_data"}, 256'(lhs_data), 256'(0));
        check({tag, "_rst_ptr"}, 256'(lhs_ptr), 256'(0));
        check({tag, "_rst_nnz"}, 256'(nnz), 256'(0));
        return;
      end
      step();
    end
    lhs_ready = 1'b0;
    check({tag, "_end_in_ready"}, 256'(in_ready), 256'(1));
    check({tag, "_end_busy"}, 256'(busy), 256'(0));
    check({tag, "_end_col"}, 256'(lhs_col), 256'(0));
    check({tag, "_end_data"}, 256'(lhs_data), 256'(0));
    check({tag, "_end_ptr"}, 256'(lhs_ptr), 256'(exp_ptr()));
    // A ready pulse while idle must not pre-arm the next burst.
    lhs_ready = 1'b1;
    step();
    lhs_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) step();
    check("reset_in_ready", 256'(in_ready), 256'(1));
    check("reset_busy", 256'(busy), 256'(0));
    check("reset_start", 256'(lhs_start), 256'(0));
    check("reset_col", 256'(lhs_col), 256'(0));
    check("reset_data", 256'(lhs_data), 256'(0));
    check("reset_ptr", 256'(lhs_ptr), 256'(0));
    check("reset_nnz", 256'(nnz), 256'(0));
    reset = 1'b0;
    step();

    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mat[r][c] = (r == c) ? 8'd1 : 8'd0;
    run_matrix("ident", 1, 1'b0, -1);

    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mat[r][c] = 8'd0;
    run_matrix("zero", 22, 1'b0, -1);

    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mat[r][c] = 8'd1;
    run_matrix("ones", 5, 1'b0, -1);

    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mat[r][c] = (r < 3 && c < 6) ? 8'(r + 1) : 8'd0;
    run_matrix("rows3", 19, 1'b0, -1);

    fill_random();
    run_matrix("hold", 30, 1'b1, -1);

    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) mat[r][c] = 8'd1;
    run_matrix("abort", 3, 1'b0, 3);

    fill_random();
    run_matrix("fresh", 25, 1'b0, -1);

    for (int t = 0; t < 8; t++) begin
      fill_random();
      run_matrix($sformatf("rand%0d", t), $urandom_range(1, 30), 1'b0, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
